// File: rtl/accum_ctrl_4bit.sv
// accum_ctrl_4bit: frames a run of input beats between a start pulse and a
// last (or MAX_BEATS-th) beat, summing them modulo 16 through a 4-bit ripple
// carry adder and keeping a sticky carry-out flag for the whole frame.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; results of the previous frame held
// S_ACCUM | accepting beats (in_ready=1); bubbles hold all registers
// S_DONE  | one-cycle done pulse; result final, no beats accepted
`timescale 1ns/1ps

module ripple_carry_adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] SUM,
  output logic       COUT
);

  logic [4:0] carry;

  // Bitwise full-adder chain, LSB first.
  always_comb begin
    carry    = '0;
    SUM      = '0;
    carry[0] = CIN;
    for (int i = 0; i < 4; i++) begin
      SUM[i]       = A[i] ^ B[i] ^ carry[i];
      carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
  end

  assign COUT = carry[4];

endmodule

module accum_ctrl_4bit #(
  parameter int MAX_BEATS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [3:0] acc_out,
  output logic       ovf,
  output logic [3:0] beat_cnt,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Compared in 5 bits so the +1 on a full 4-bit count cannot alias.
  localparam logic [4:0] MAX_B = 5'(MAX_BEATS);

  state_t     state_q, state_d;
  logic [3:0] acc_q, acc_d;
  logic       ovf_q, ovf_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] add_sum;
  logic       add_cout;
  logic [4:0] cnt_inc;
  logic       beat;

  ripple_carry_adder_4bit u_adder (
    .A    (acc_q),
    .B    (in_data),
    .CIN  (1'b0),
    .SUM  (add_sum),
    .COUT (add_cout)
  );

  // Handshake and status decode purely from the registered state.
  assign in_ready = (state_q == S_ACCUM);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign acc_out  = acc_q;
  assign ovf      = ovf_q;
  assign beat_cnt = cnt_q;

  assign beat    = in_valid & in_ready;
  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  // Next-state and datapath update; everything holds unless a rule fires.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_ACCUM: begin
        if (beat) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_cout;
          cnt_d = cnt_inc[3:0];
          if (in_last || (cnt_inc == MAX_B)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulator, sticky overflow and beat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_accum_ctrl_4bit.sv
// Bench for accum_ctrl_4bit: directed frames followed by random traffic,
// all checked against a frame-level model (running integer sum of beats).
`timescale 1ns/1ps

module tb_accum_ctrl_4bit;

  localparam int MAXB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [3:0] acc_out;
  logic       ovf;
  logic [3:0] beat_cnt;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 accumulating, 2 done; sum is the unbounded
  // integer total of the frame's beats, so acc = sum mod 16 and, as all
  // operands are non-negative, overflow happened iff sum reached 16.
  int m_phase = 0;
  int m_sum   = 0;
  int m_cnt   = 0;

  accum_ctrl_4bit #(.MAX_BEATS(MAXB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .acc_out  (acc_out),
    .ovf      (ovf),
    .beat_cnt (beat_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed view: {in_ready, busy, done, ovf, beat_cnt, acc_out}
  task automatic chk_model(input string tag);
    logic [11:0] obs, exp;
    logic [3:0]  e_acc, e_cnt;
    e_acc = 4'(m_sum % 16);
    e_cnt = 4'(m_cnt);
    obs = {in_ready, busy, done, ovf, beat_cnt, acc_out};
    exp = {(m_phase == 1), (m_phase != 0), (m_phase == 2), (m_sum >= 16), e_cnt, e_acc};
    chk(tag, obs, exp);
  endtask

  task automatic model_edge(input logic s, input logic v, input logic [3:0] d, input logic l);
    case (m_phase)
      0: if (s) begin m_phase = 1; m_sum = 0; m_cnt = 0; end
      1: if (v) begin
           m_sum += int'(d);
           m_cnt++;
           if (l || m_cnt == MAXB) m_phase = 2;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step(input logic s, input logic v, input logic [3:0] d, input logic l);
    start = s; in_valid = v; in_data = d; in_last = l;
    @(posedge clk);
    model_edge(s, v, d, l);
    #1;
    chk_model("cycle");
  endtask

  // Async reset pulse placed between edges, checked before the next edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    m_phase = 0; m_sum = 0; m_cnt = 0;
    chk({"async_rst"}, {in_ready, busy, done, ovf, beat_cnt, acc_out}, 12'h000);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; in_valid = 0; in_data = 0; in_last = 0;
    #12;
    chk("reset_state", {in_ready, busy, done, ovf, beat_cnt, acc_out}, 12'h000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-run
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd5, 0);
    step(0, 1, 4'd6, 0);
    chk("pre_rst_acc", {8'h0, acc_out}, 12'h00B);
    mid_reset();
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd3, 1);
    chk("after_rst_acc", {8'h0, acc_out}, 12'h003);
    step(0, 0, 4'd0, 0);

    // Normal frame
    step(1, 0, 4'd0, 0);
    chk("ready_after_start", {11'h0, in_ready}, 12'h001);
    step(0, 1, 4'd3, 0);
    chk("norm_acc1", {8'h0, acc_out}, 12'h003);
    step(0, 1, 4'd4, 0);
    chk("norm_acc2", {8'h0, acc_out}, 12'h007);
    step(0, 1, 4'd5, 1);
    chk("norm_done", {in_ready, busy, done, ovf, beat_cnt, acc_out}, 12'h63C);
    step(0, 0, 4'd0, 0);
    chk("norm_idle", {10'h0, busy, done}, 12'h000);

    // Overflow, then a clean single-beat frame back to back
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd9, 0);
    step(0, 1, 4'd9, 1);
    chk("ovf_frame", {3'b0, ovf, beat_cnt, acc_out}, 12'h122);
    step(0, 0, 4'd0, 0);
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd15, 1);
    chk("ovf_cleared", {3'b0, ovf, beat_cnt, acc_out}, 12'h01F);
    step(0, 0, 4'd0, 0);

    // Forced termination at MAX_BEATS
    step(1, 0, 4'd0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 4'd1, 0);
    chk("forced_end", {3'b0, ovf, beat_cnt, acc_out}, 12'h088);
    step(0, 0, 4'd0, 0);

    // Bubbles and ignored start
    step(1, 0, 4'd0, 0);
    step(0, 1, 4'd2, 0);
    step(0, 0, 4'd0, 0);
    step(1, 0, 4'd9, 0);
    step(0, 0, 4'd0, 0);
    step(0, 1, 4'd1, 1);
    chk("bubble_frame", {4'b0, beat_cnt, acc_out}, 12'h023);
    step(0, 0, 4'd0, 0);

    // Start and valid in the same IDLE cycle
    step(1, 1, 4'd7, 0);
    chk("start_valid_cnt", {8'h0, beat_cnt}, 12'h000);
    step(0, 1, 4'd7, 1);
    chk("start_valid_acc", {8'h0, acc_out}, 12'h007);
    step(0, 0, 4'd0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        mid_reset();
        step(0, 0, 4'd0, 0);
      end else begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
             4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accum_ctrl_4bit.md
# accum_ctrl_4bit

Sequential accumulation controller that sits directly upstream of `ripple_carry_adder_4bit` and consumes its result. It drives the adder with `A` = running accumulator, `B` = incoming data and `CIN` = 0. On each accepted input beat it registers `SUM` back into the accumulator and folds `COUT` into a sticky overflow flag. A small FSM frames each accumulation between a `start` pulse and a last beat, with a valid/ready input handshake.

## Interface
- `MAX_BEATS`, default 8: maximum beats per accumulation; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a new accumulation; honoured only in IDLE.
- `in_valid` in 1: `in_data`/`in_last` are valid.
- `in_data` in 4: operand added to the accumulator.
- `in_last` in 1: final beat of the current accumulation.
- `in_ready` out 1: block accepts a beat this cycle.
- `acc_out` out 4: accumulator value.
- `ovf` out 1: sticky; at least one adder `COUT`=1 in the current accumulation.
- `beat_cnt` out 4: beats accepted in the current accumulation.
- `busy` out 1: high in ACCUM and DONE.
- `done` out 1: one-cycle pulse; result is final.

## Operation
- Internally instantiates `ripple_carry_adder_4bit`: `A`=`acc`, `B`=`in_data`, `CIN`=0. `SUM` and `COUT` are used combinationally.
- States:
  - IDLE: `in_ready`=0, `busy`=0.
  - ACCUM: `in_ready`=1, `busy`=1.
  - DONE: `done`=1, `busy`=1, `in_ready`=0.
- IDLE, `start`=1: go to ACCUM. At the same edge, `acc`←0, `ovf`←0, `beat_cnt`←0. `start`=0 stays in IDLE.
- ACCUM, beat (`in_valid` & `in_ready`):
  - `acc`←`SUM`
  - `ovf`←`ovf` | `COUT`
  - `beat_cnt`←`beat_cnt`+1
  - Go to DONE if `in_last`=1 or `beat_cnt`+1 == `MAX_BEATS`; otherwise stay in ACCUM.
- ACCUM, no beat: all registers hold (bubbles are free).
- DONE: go to IDLE unconditionally after one cycle.
- `start` in ACCUM or DONE is ignored, with no effect on state or data.
- `acc_out`, `ovf` and `beat_cnt` hold their final values through DONE and IDLE until the next accepted `start`.
- Arithmetic is modulo 16. A wrap sets `ovf`, which is never cleared except by `start` (in IDLE) or `rst`.
- `in_data`/`in_last` are ignored whenever `in_ready`=0.

## Timing
- Reset, asynchronous and immediate on `rst`=1:
  - state=IDLE
  - `acc_out`=0, `ovf`=0, `beat_cnt`=0
  - `in_ready`=0, `busy`=0, `done`=0
- Reset mid-accumulation discards partial results. The first edge after deassertion is in IDLE.
- `in_ready` and `busy` decode from the registered state only; there is no combinational path from inputs.
- `start` accepted at edge N: `in_ready`=1 from cycle N+1. A beat offered in cycle N is not accepted.
- Beat accepted at edge K: `acc_out`/`ovf`/`beat_cnt` show updated values in cycle K+1.
- Final beat at edge K: `done`=1 during cycle K+1 only, and the state is IDLE in cycle K+2.
- Minimum frame: `start`, then 1 beat, then DONE, giving 3 cycles start-to-IDLE.
- Back-to-back: the earliest next `start` is accepted in the first IDLE cycle after DONE.
- `beat_cnt` never exceeds `MAX_BEATS`. With `MAX_BEATS`=15, the 15th beat forces DONE.

## Test plan
- **Reset mid-run.** `start`, beats 5 and 6, then assert `rst` asynchronously between edges. Required: all outputs 0 immediately, state IDLE. A following `start` plus beat 3 with `in_last` gives `acc_out`=3.
- **Normal frame.** `start`, then beats 3, 4, 5 with `in_last` on 5, `in_valid` continuous. Required: `acc_out` 3→7→12, `ovf`=0, `beat_cnt`=3, `done` one cycle after the beat-5 edge, `in_ready`=0 during DONE.
- **Overflow.** Beats 9, then 9 with `in_last`. Required: `acc_out`=2, `ovf`=1, `beat_cnt`=2. Next frame of a single beat 15 with `in_last`: `acc_out`=15, `ovf`=0.
- **Forced termination** (`MAX_BEATS`=8). Nine beats of 1 with `in_valid` held high and `in_last`=0. Required: `acc_out`=8, `beat_cnt`=8, `done` after the 8th beat, 9th beat not accepted, `ovf`=0.
- **Bubbles and ignored start.** Beats 2, gap of 3 cycles with `in_valid`=0, then beat 1 with `in_last`; `start` pulsed during the gap. Required: `acc_out`=3, `beat_cnt`=2, frame not restarted.
- **Start and valid same cycle.** In IDLE, `start`=1 and `in_valid`=1 with data 7. Required: no beat that cycle, `beat_cnt`=0; beat 7 accepted in the next cycle gives `acc_out`=7.
